// File: rtl/nn_frame_loader.sv
// nn_frame_loader: initiator side of the neural_network start/done/argmax handshake.
// Collects a row-major binary frame from a serial pixel stream, presents it on pixel_data,
// pulses nn_start, waits for nn_done (or a timeout) and holds the result until acknowledged.
//
// Ports:
//   clk, resetn          clock; asynchronous reset, active-high despite the name
//   pix_valid/pix_bit    serial pixel stream, accepted when pix_ready is high
//   pix_ready            loader is in LOAD and will take a pixel this cycle
//   frame_abort          LOAD: restart the frame; HOLD: acts as result_ack
//   pixel_data           assembled image, bit i = pixel i
//   nn_start             one-cycle start pulse; nn_done/nn_argmax: network result
//   result_valid/digit   captured digit (4'hF on timeout), held until result_ack
//   timeout_err          qualifies result_valid as a timeout result
//   busy                 high while the network is started or running
module nn_frame_loader #(
  parameter int unsigned NUM_PIXELS     = 784,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned TO_W           = 21
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pix_valid,
  input  logic                  pix_bit,
  output logic                  pix_ready,
  input  logic                  frame_abort,
  output logic [NUM_PIXELS-1:0] pixel_data,
  output logic                  nn_start,
  input  logic                  nn_done,
  input  logic [3:0]            nn_argmax,
  output logic                  result_valid,
  output logic [3:0]            result_digit,
  input  logic                  result_ack,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int unsigned CntW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  typedef enum logic [1:0] {StLoad, StFire, StWait, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [NUM_PIXELS-1:0] pixel_data_q, pixel_data_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  result_valid_q, result_valid_d;
  logic [3:0]            result_digit_q, result_digit_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  nn_start_q, nn_start_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    pixel_data_d   = pixel_data_q;
    to_cnt_d       = to_cnt_q;
    result_valid_d = result_valid_q;
    result_digit_d = result_digit_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      StLoad: begin
        // Abort takes priority over a pixel offered in the same cycle.
        if (frame_abort) begin
          pix_cnt_d = '0;
        end else if (pix_valid && pix_ready_q) begin
          pixel_data_d[pix_cnt_q] = pix_bit;
          if (pix_cnt_q == CntW'(NUM_PIXELS - 1)) begin
            pix_cnt_d = '0;
            state_d   = StFire;
          end else begin
            pix_cnt_d = pix_cnt_q + CntW'(1);
          end
        end
      end
      StFire: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A done on the terminal-count cycle still counts as a real result.
        if (nn_done) begin
          result_digit_d = nn_argmax;
          timeout_err_d  = 1'b0;
          result_valid_d = 1'b1;
          state_d        = StHold;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          result_digit_d = 4'hF;
          timeout_err_d  = 1'b1;
          result_valid_d = 1'b1;
          state_d        = StHold;
        end
      end
      StHold: begin
        if (result_ack || frame_abort) begin
          result_valid_d = 1'b0;
          timeout_err_d  = 1'b0;
          pix_cnt_d      = '0;
          state_d        = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    // Outputs are registered from the next state so they line up with it.
    pix_ready_d = (state_d == StLoad);
    nn_start_d  = (state_d == StFire);
    busy_d      = (state_d == StFire) || (state_d == StWait);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q        <= StLoad;
      pix_cnt_q      <= '0;
      pixel_data_q   <= '0;
      to_cnt_q       <= '0;
      result_valid_q <= 1'b0;
      result_digit_q <= 4'h0;
      timeout_err_q  <= 1'b0;
      pix_ready_q    <= 1'b0;
      nn_start_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      pixel_data_q   <= pixel_data_d;
      to_cnt_q       <= to_cnt_d;
      result_valid_q <= result_valid_d;
      result_digit_q <= result_digit_d;
      timeout_err_q  <= timeout_err_d;
      pix_ready_q    <= pix_ready_d;
      nn_start_q     <= nn_start_d;
      busy_q         <= busy_d;
    end
  end

  assign pix_ready    = pix_ready_q;
  assign pixel_data   = pixel_data_q;
  assign nn_start     = nn_start_q;
  assign result_valid = result_valid_q;
  assign result_digit = result_digit_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Self-checking bench for nn_frame_loader: randomized frames, gaps, aborts, done/timeout
// timing and a mid-WAIT reset, checked against a transaction-level reference model.
module tb_nn_frame_loader;

  localparam int unsigned NP = 784;
  localparam int unsigned T  = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          pix_valid, pix_bit, pix_ready, frame_abort;
  logic [NP-1:0] pixel_data;
  logic          nn_start, nn_done;
  logic [3:0]    nn_argmax;
  logic          result_valid;
  logic [3:0]    result_digit;
  logic          result_ack, timeout_err, busy;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int exp_starts = 0;

  logic [NP-1:0] img = '0;

  nn_frame_loader #(
    .NUM_PIXELS    (NP),
    .TIMEOUT_CYCLES(T),
    .TO_W          (5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pix_valid   (pix_valid),
    .pix_bit     (pix_bit),
    .pix_ready   (pix_ready),
    .frame_abort (frame_abort),
    .pixel_data  (pixel_data),
    .nn_start    (nn_start),
    .nn_done     (nn_done),
    .nn_argmax   (nn_argmax),
    .result_valid(result_valid),
    .result_digit(result_digit),
    .result_ack  (result_ack),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Each start pulse is one cycle wide, so one negedge sample per pulse.
  always @(negedge clk) if (nn_start === 1'b1) start_cnt++;

  task automatic check_val(input string tag, input logic [NP-1:0] obs,
                           input logic [NP-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pix_valid   = 1'b0;
    pix_bit     = 1'b0;
    frame_abort = 1'b0;
    nn_done     = 1'b0;
    nn_argmax   = 4'h0;
    result_ack  = 1'b0;
  endtask

  // Streams one frame; abort_at < 0 means no abort. Returns just after the FIRE edge.
  task automatic load_frame(input int abort_at, input bit gaps, input bit alt);
    int cnt = 0;
    int guard = 0;
    bit aborted = 1'b0;
    bit v, b, a;
    while (cnt < NP) begin
      @(negedge clk);
      check_val("pix_ready_load", pix_ready, 1'b1);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      b = alt ? cnt[0] : 1'($urandom);
      a = !aborted && (cnt == abort_at);
      if (a) v = 1'b1;
      pix_valid   = v;
      pix_bit     = b;
      frame_abort = a;
      nn_done     = 1'($urandom);
      nn_argmax   = 4'($urandom);
      result_ack  = 1'($urandom);
      @(posedge clk);
      if (a) begin
        cnt = 0;
        aborted = 1'b1;
      end else if (v) begin
        img[cnt] = b;
        cnt++;
      end
      #1;
      if (cnt < NP) check_val("busy_load", busy, 1'b0);
      guard++;
      if (guard > 8 * NP) begin
        check_val("load_guard", 1'b1, 1'b0);
        break;
      end
    end
    exp_starts++;
    check_val("pix_ready_fire", pix_ready, 1'b0);
    check_val("nn_start_fire", nn_start, 1'b1);
    check_val("busy_fire", busy, 1'b1);
    check_val("pixel_data", pixel_data, img);
  endtask

  // d = WAIT edge (1-based) carrying nn_done; d > T means no done (timeout).
  task automatic wait_phase(input int d, input logic [3:0] am);
    int last;
    bit done;
    done = (d <= int'(T));
    last = done ? d : int'(T);
    @(negedge clk);
    nn_done     = 1'b1;
    nn_argmax   = 4'($urandom);
    frame_abort = 1'($urandom);
    result_ack  = 1'($urandom);
    pix_valid   = 1'($urandom);
    @(posedge clk); #1;
    check_val("nn_start_wait", nn_start, 1'b0);
    check_val("busy_wait", busy, 1'b1);
    check_val("valid_fire", result_valid, 1'b0);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      nn_done     = (k == d);
      nn_argmax   = (k == d) ? am : 4'($urandom);
      frame_abort = 1'($urandom);
      result_ack  = 1'($urandom);
      pix_valid   = 1'($urandom);
      @(posedge clk); #1;
      check_val("pixel_data_stable", pixel_data, img);
      if (k < last) begin
        check_val("valid_early", result_valid, 1'b0);
        check_val("busy_wait", busy, 1'b1);
      end else begin
        check_val("valid_set", result_valid, 1'b1);
        check_val("digit", result_digit, done ? am : 4'hF);
        check_val("timeout_err", timeout_err, !done);
        check_val("busy_hold", busy, 1'b0);
        check_val("pix_ready_hold", pix_ready, 1'b0);
      end
    end
    check_val("start_cnt", start_cnt, exp_starts);
  endtask

  task automatic hold_phase(input int n, input bit use_abort, input logic [3:0] dig,
                            input bit to);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      result_ack  = 1'b0;
      frame_abort = 1'b0;
      nn_done     = 1'($urandom);
      nn_argmax   = 4'($urandom);
      pix_valid   = 1'($urandom);
      @(posedge clk); #1;
      check_val("valid_held", result_valid, 1'b1);
      check_val("digit_held", result_digit, dig);
      check_val("to_held", timeout_err, to);
    end
    @(negedge clk);
    result_ack  = !use_abort;
    frame_abort = use_abort;
    @(posedge clk); #1;
    check_val("valid_ack", result_valid, 1'b0);
    check_val("to_ack", timeout_err, 1'b0);
    check_val("digit_kept", result_digit, dig);
    check_val("pix_ready_ack", pix_ready, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pix_ready"}, pix_ready, 1'b0);
    check_val({tag, "_nn_start"}, nn_start, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_valid"}, result_valid, 1'b0);
    check_val({tag, "_digit"}, result_digit, 4'h0);
    check_val({tag, "_to"}, timeout_err, 1'b0);
    check_val({tag, "_pixel_data"}, pixel_data, '0);
  endtask

  initial begin
    int abort_at, d;
    logic [3:0] am;
    idle_inputs();
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("pix_ready_pre_edge", pix_ready, 1'b0);
    @(posedge clk); #1;
    check_val("pix_ready_post_rst", pix_ready, 1'b1);

    // Alternating pattern, no gaps, done with 7.
    load_frame(-1, 1'b0, 1'b1);
    wait_phase(3, 4'd7);
    hold_phase(2, 1'b0, 4'd7, 1'b0);

    // Timeout, released through frame_abort in HOLD.
    load_frame(-1, 1'b1, 1'b0);
    wait_phase(T + 5, 4'd0);
    hold_phase(1, 1'b1, 4'hF, 1'b1);

    // Abort after 100 pixels; done on the terminal-count cycle wins.
    load_frame(100, 1'b1, 1'b0);
    wait_phase(T, 4'd3);
    hold_phase(0, 1'b0, 4'd3, 1'b0);

    // Reset pulsed mid-WAIT.
    load_frame(-1, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nn_done   = 1'($urandom);
      nn_argmax = 4'($urandom);
      @(posedge clk); #1;
      check_val("post_rst_valid", result_valid, 1'b0);
      check_val("post_rst_busy", busy, 1'b0);
    end
    check_val("post_rst_ready", pix_ready, 1'b1);
    check_val("post_rst_starts", start_cnt, exp_starts);
    @(negedge clk);
    idle_inputs();

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      d        = int'($urandom_range(1, T + 3));
      am       = 4'($urandom_range(0, 9));
      load_frame(abort_at, 1'b1, 1'b0);
      wait_phase(d, am);
      hold_phase(int'($urandom_range(0, 3)), 1'($urandom), (d <= int'(T)) ? am : 4'hF,
                 d > int'(T));
    end

    check_val("final_starts", start_cnt, exp_starts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
